// File: rtl/scpad_be_tile_fetch.sv
// Scratchpad backend tile-fetch engine: DRAM row reads in, masked SRAM row writes out.
// Build option: SCPAD_FETCH_ZERO_FILL_EN writes full rows with out-of-tile columns zeroed.
package spad_types_pkg;
    localparam int DRAM_ADDR_WIDTH  = 32;
    localparam int SCPAD_ID_WIDTH   = 1;
    localparam int MAX_DIM_WIDTH    = 5;
    localparam int DRAM_ID_WIDTH    = SCPAD_ID_WIDTH + MAX_DIM_WIDTH;
    localparam int NUM_ROWS         = 16384;
    localparam int ROW_IDX_WIDTH    = 14;
    localparam int NUM_COLS         = 32;
    localparam int ELEM_WIDTH       = 16;
    localparam int ROW_SHIFT        = 6;
    localparam int SCPAD_ADDR_WIDTH = ROW_IDX_WIDTH + ROW_SHIFT;

    typedef logic [NUM_COLS-1:0][ELEM_WIDTH-1:0] scpad_data_t;
    typedef logic [NUM_COLS-1:0]                 mask_t;
endpackage

module scpad_be_tile_fetch
    import spad_types_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DRAM_ADDR_WIDTH-1:0]  cmd_dram_addr,
    input  logic [DRAM_ADDR_WIDTH-1:0]  cmd_dram_stride,
    input  logic [SCPAD_ADDR_WIDTH-1:0] cmd_spad_addr,
    input  logic [MAX_DIM_WIDTH-1:0]    cmd_rows_m1,
    input  logic [MAX_DIM_WIDTH-1:0]    cmd_cols_m1,
    input  logic [SCPAD_ID_WIDTH-1:0]   cmd_scpad_id,
    output logic                        dram_req_valid,
    input  logic                        dram_req_ready,
    output logic [DRAM_ADDR_WIDTH-1:0]  dram_req_addr,
    output logic [DRAM_ID_WIDTH-1:0]    dram_req_id,
    input  logic                        dram_resp_valid,
    output logic                        dram_resp_ready,
    input  logic [DRAM_ID_WIDTH-1:0]    dram_resp_id,
    input  scpad_data_t                 dram_resp_data,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [SCPAD_ID_WIDTH-1:0]   wr_scpad_id,
    output logic [ROW_IDX_WIDTH-1:0]    wr_row,
    output scpad_data_t                 wr_data,
    output mask_t                       wr_mask,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] OUTS_MAX = CNT_W'(MAX_OUTSTANDING);

    state_e                       state_q, state_d;
    logic                         started_q;
    logic [DRAM_ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DRAM_ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [ROW_IDX_WIDTH-1:0]     row_base_q, row_base_d;
    logic [MAX_DIM_WIDTH-1:0]     rows_m1_q, rows_m1_d;
    logic [MAX_DIM_WIDTH-1:0]     cols_m1_q, cols_m1_d;
    logic [MAX_DIM_WIDTH-1:0]     iss_q, iss_d;
    logic [SCPAD_ID_WIDTH-1:0]    sid_q, sid_d;
    logic [31:0]                  rcvd_q, rcvd_d;
    logic [CNT_W-1:0]             outs_q, outs_d;
    logic                         err_q, err_d;
    logic                         wr_valid_q, wr_valid_d;
    logic [ROW_IDX_WIDTH-1:0]     wr_row_q, wr_row_d;
    scpad_data_t                  wr_data_q, wr_data_d;
    mask_t                        wr_mask_q, wr_mask_d;

    logic                         active;
    logic                         wr_free;
    logic                         req_hs;
    logic                         resp_hs;
    logic                         resp_ok;
    logic                         good_hs;
    logic                         all_rcvd;
    logic [31:0]                  need;
    mask_t                        col_mask;
    mask_t                        fill_mask;
    scpad_data_t                  fill_data;
    logic [MAX_DIM_WIDTH-1:0]     resp_row;
    logic [SCPAD_ID_WIDTH-1:0]    resp_sid;
    logic                         unused_spad_lsb;

    assign unused_spad_lsb = ^cmd_spad_addr[ROW_SHIFT-1:0];

    assign resp_row = dram_resp_id[MAX_DIM_WIDTH-1:0];
    assign resp_sid = dram_resp_id[DRAM_ID_WIDTH-1 -: SCPAD_ID_WIDTH];
    assign active   = (state_q == ISSUE) || (state_q == DRAIN);
    assign wr_free  = !wr_valid_q || wr_ready;
    assign req_hs   = dram_req_valid && dram_req_ready;
    assign resp_hs  = dram_resp_valid && dram_resp_ready;
    assign resp_ok  = (resp_sid == sid_q)
                   && (resp_row <= rows_m1_q)
                   && !rcvd_q[resp_row];
    assign good_hs  = active && resp_hs && resp_ok;

    always_comb begin
        need     = '0;
        col_mask = '0;
        for (int i = 0; i < 32; i++) begin
            need[i]     = MAX_DIM_WIDTH'(i) <= rows_m1_q;
            col_mask[i] = MAX_DIM_WIDTH'(i) <= cols_m1_q;
        end
        all_rcvd = &(rcvd_q | ~need);
    end

    // Zero-fill build clears stale scratchpad data beyond the tile width.
    always_comb begin
        fill_data = dram_resp_data;
        fill_mask = col_mask;
`ifdef SCPAD_FETCH_ZERO_FILL_EN
        fill_mask = '1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!col_mask[c]) begin
                fill_data[c] = '0;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        rows_m1_d  = rows_m1_q;
        cols_m1_d  = cols_m1_q;
        iss_d      = iss_q;
        sid_d      = sid_q;
        rcvd_d     = rcvd_q;
        outs_d     = outs_q;
        err_d      = err_q;
        wr_valid_d = wr_valid_q;
        wr_row_d   = wr_row_q;
        wr_data_d  = wr_data_q;
        wr_mask_d  = wr_mask_q;

        cmd_ready       = 1'b0;
        dram_req_valid  = 1'b0;
        dram_resp_ready = 1'b0;
        done            = 1'b0;

        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cmd_ready       = started_q;
                dram_resp_ready = started_q;
                if (cmd_valid && started_q) begin
                    req_addr_d = cmd_dram_addr;
                    stride_d   = cmd_dram_stride;
                    row_base_d = cmd_spad_addr[SCPAD_ADDR_WIDTH-1:ROW_SHIFT];
                    rows_m1_d  = cmd_rows_m1;
                    cols_m1_d  = cmd_cols_m1;
                    sid_d      = cmd_scpad_id;
                    iss_d      = '0;
                    rcvd_d     = '0;
                    outs_d     = '0;
                    err_d      = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                dram_req_valid  = outs_q < OUTS_MAX;
                dram_resp_ready = wr_free;
                if (req_hs) begin
                    iss_d      = iss_q + MAX_DIM_WIDTH'(1);
                    req_addr_d = req_addr_q + stride_q;
                    if (iss_q == rows_m1_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dram_resp_ready = wr_free;
                if (all_rcvd && wr_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done            = 1'b1;
                dram_resp_ready = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outside an active tile, responses are swallowed without flagging.
        if (active && resp_hs) begin
            if (resp_ok) begin
                wr_valid_d       = 1'b1;
                wr_row_d         = row_base_q + ROW_IDX_WIDTH'(resp_row);
                wr_data_d        = fill_data;
                wr_mask_d        = fill_mask;
                rcvd_d[resp_row] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (active && req_hs && !good_hs) begin
            outs_d = outs_q + CNT_W'(1);
        end else if (!req_hs && good_hs) begin
            outs_d = outs_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            started_q  <= 1'b0;
            req_addr_q <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            rows_m1_q  <= '0;
            cols_m1_q  <= '0;
            iss_q      <= '0;
            sid_q      <= '0;
            rcvd_q     <= '0;
            outs_q     <= '0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_row_q   <= '0;
            wr_data_q  <= '0;
            wr_mask_q  <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            req_addr_q <= req_addr_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            rows_m1_q  <= rows_m1_d;
            cols_m1_q  <= cols_m1_d;
            iss_q      <= iss_d;
            sid_q      <= sid_d;
            rcvd_q     <= rcvd_d;
            outs_q     <= outs_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_row_q   <= wr_row_d;
            wr_data_q  <= wr_data_d;
            wr_mask_q  <= wr_mask_d;
        end
    end

    assign dram_req_addr = req_addr_q;
    assign dram_req_id   = {sid_q, iss_q};
    assign wr_valid      = wr_valid_q;
    assign wr_scpad_id   = sid_q;
    assign wr_row        = wr_row_q;
    assign wr_data       = wr_data_q;
    assign wr_mask       = wr_mask_q;
    assign err           = err_q;

endmodule

// File: tb/tb_scpad_be_tile_fetch.sv
// Randomized bench for scpad_be_tile_fetch against a queue-based tile model.
module tb_scpad_be_tile_fetch;
    import spad_types_pkg::*;

    localparam int MAXO = 8;

    logic                        CLK = 1'b0;
    logic                        nRST;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [DRAM_ADDR_WIDTH-1:0]  cmd_dram_addr;
    logic [DRAM_ADDR_WIDTH-1:0]  cmd_dram_stride;
    logic [SCPAD_ADDR_WIDTH-1:0] cmd_spad_addr;
    logic [MAX_DIM_WIDTH-1:0]    cmd_rows_m1;
    logic [MAX_DIM_WIDTH-1:0]    cmd_cols_m1;
    logic [SCPAD_ID_WIDTH-1:0]   cmd_scpad_id;
    logic                        dram_req_valid;
    logic                        dram_req_ready;
    logic [DRAM_ADDR_WIDTH-1:0]  dram_req_addr;
    logic [DRAM_ID_WIDTH-1:0]    dram_req_id;
    logic                        dram_resp_valid;
    logic                        dram_resp_ready;
    logic [DRAM_ID_WIDTH-1:0]    dram_resp_id;
    scpad_data_t                 dram_resp_data;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [SCPAD_ID_WIDTH-1:0]   wr_scpad_id;
    logic [ROW_IDX_WIDTH-1:0]    wr_row;
    scpad_data_t                 wr_data;
    mask_t                       wr_mask;
    logic                        done;
    logic                        err;

    scpad_be_tile_fetch #(.MAX_OUTSTANDING(MAXO)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dram_addr   (cmd_dram_addr),
        .cmd_dram_stride (cmd_dram_stride),
        .cmd_spad_addr   (cmd_spad_addr),
        .cmd_rows_m1     (cmd_rows_m1),
        .cmd_cols_m1     (cmd_cols_m1),
        .cmd_scpad_id    (cmd_scpad_id),
        .dram_req_valid  (dram_req_valid),
        .dram_req_ready  (dram_req_ready),
        .dram_req_addr   (dram_req_addr),
        .dram_req_id     (dram_req_id),
        .dram_resp_valid (dram_resp_valid),
        .dram_resp_ready (dram_resp_ready),
        .dram_resp_id    (dram_resp_id),
        .dram_resp_data  (dram_resp_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_scpad_id     (wr_scpad_id),
        .wr_row          (wr_row),
        .wr_data         (wr_data),
        .wr_mask         (wr_mask),
        .done            (done),
        .err             (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ROW_IDX_WIDTH-1:0] row;
        scpad_data_t              data;
        mask_t                    mask;
    } wr_t;

    int        checks = 0;
    int        errors = 0;
    int        pool[$];
    wr_t       expq[$];
    bit [31:0] rcvd_m;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic scpad_data_t rand_data();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    function automatic wr_t exp_wr(int base, int row, scpad_data_t d, int cm1);
        wr_t e;
        e.row = ROW_IDX_WIDTH'((base + row) % NUM_ROWS);
        for (int c = 0; c < NUM_COLS; c++) begin
`ifdef SCPAD_FETCH_ZERO_FILL_EN
            e.mask[c] = 1'b1;
            e.data[c] = (c <= cm1) ? d[c] : '0;
`else
            e.mask[c] = (c <= cm1);
            e.data[c] = d[c];
`endif
        end
        return e;
    endfunction

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] stride,
                            input logic [19:0] spad, input int rm1,
                            input int cm1, input logic sid);
        int n = 0;
        @(negedge CLK);
        cmd_dram_addr   = addr;
        cmd_dram_stride = stride;
        cmd_spad_addr   = spad;
        cmd_rows_m1     = 5'(rm1);
        cmd_cols_m1     = 5'(cm1);
        cmd_scpad_id    = sid;
        cmd_valid       = 1'b1;
        #1;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    // order: 0 in-order, 1 newest-first, 2 random
    task automatic run_tile(input logic [31:0] addr, input logic [31:0] stride,
                            input logic [19:0] spad, input int rm1,
                            input int cm1, input logic sid, input int order,
                            input bit stall, input bit bad);
        int iss = 0, outs = 0, nrcv = 0, cyc = 0, hold_lo = 0;
        int base, row, idx;
        bit err_m = 0, held = 0, done_seen = 0, pw = 0;
        logic [ROW_IDX_WIDTH-1:0] prow;
        scpad_data_t pdata;
        logic [31:0] ea;
        int rl[$];
        base = int'(spad >> ROW_SHIFT);
        pool.delete();
        expq.delete();
        rcvd_m = '0;
        send_cmd(addr, stride, spad, rm1, cm1, sid);
        while (!done_seen && cyc < 4000) begin
            @(negedge CLK);
            cyc++;
            if (stall) begin
                if (hold_lo == 0 && $urandom_range(0, 11) == 0) hold_lo = 5;
                wr_ready = (hold_lo == 0) && ($urandom_range(0, 4) != 0);
                if (hold_lo > 0) hold_lo--;
                dram_req_ready = ($urandom_range(0, 3) != 0);
            end else begin
                wr_ready       = 1'b1;
                dram_req_ready = 1'b1;
            end
            if (!held) begin
                dram_resp_valid = 1'b0;
                dram_resp_data  = rand_data();
                if (pool.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
                    if (bad && $urandom_range(0, 5) == 0) begin
                        rl.delete();
                        for (int r = 0; r <= rm1; r++)
                            if (rcvd_m[r]) rl.push_back(r);
                        idx = $urandom_range(0, 2);
                        if (idx == 0 && rl.size() > 0)
                            dram_resp_id = {sid, 5'(rl[$urandom_range(0, rl.size()-1)])};
                        else if (idx == 1 && rm1 < 31)
                            dram_resp_id = {sid, 5'($urandom_range(rm1 + 1, 31))};
                        else
                            dram_resp_id = {~sid, 5'($urandom_range(0, rm1))};
                        dram_resp_valid = 1'b1;
                    end else begin
                        idx = -1;
                        if (order == 0) idx = 0;
                        else if (order == 1) begin
                            if (pool.size() == MAXO || iss > rm1) idx = pool.size() - 1;
                        end else idx = $urandom_range(0, pool.size() - 1);
                        if (idx >= 0) begin
                            dram_resp_id    = {sid, 5'(pool[idx])};
                            dram_resp_valid = 1'b1;
                        end
                    end
                end
            end
            #1;
            chk("err", err, err_m);
            if (done) begin
                chk("done_complete", (iss == rm1 + 1) && (nrcv == rm1 + 1)
                    && (expq.size() == 0), 1'b1);
                chk("done_wr_idle", wr_valid, 1'b0);
                done_seen = 1;
            end else begin
                chk("req_valid", dram_req_valid, (iss <= rm1) && (outs < MAXO));
                chk("resp_ready", dram_resp_ready, !wr_valid || wr_ready);
            end
            if (pw) begin
                chk("wr_hold_row", wr_row, prow);
                chk("wr_hold_data", wr_data, pdata);
            end
            if (dram_req_valid) begin
                ea = addr + iss * stride;
                chk("req_addr", dram_req_addr, ea);
                chk("req_id", dram_req_id, {sid, 5'(iss)});
                if (dram_req_ready) begin
                    pool.push_back(iss);
                    iss++;
                    outs++;
                end
            end
            if (wr_valid) begin
                if (expq.size() == 0) begin
                    chk("wr_unexpected", wr_valid, 1'b0);
                end else begin
                    chk("wr_row", wr_row, expq[0].row);
                    chk("wr_data", wr_data, expq[0].data);
                    chk("wr_mask", wr_mask, expq[0].mask);
                    chk("wr_sid", wr_scpad_id, sid);
                    if (wr_ready) void'(expq.pop_front());
                end
            end
            pw    = wr_valid && !wr_ready;
            prow  = wr_row;
            pdata = wr_data;
            if (dram_resp_valid && dram_resp_ready && !done) begin
                row = int'(dram_resp_id[4:0]);
                if (dram_resp_id[5] == sid && row <= rm1 && !rcvd_m[row]) begin
                    rcvd_m[row] = 1'b1;
                    nrcv++;
                    outs--;
                    expq.push_back(exp_wr(base, row, dram_resp_data, cm1));
                    for (int i = 0; i < pool.size(); i++)
                        if (pool[i] == row) begin
                            pool.delete(i);
                            break;
                        end
                end else begin
                    err_m = 1;
                end
                held = 0;
            end else begin
                held = dram_resp_valid;
            end
        end
        chk("tile_done", done_seen, 1'b1);
        @(negedge CLK);
        dram_resp_valid = 1'b0;
        #1;
        chk("ready_after_done", cmd_ready, 1'b1);
        chk("done_single", done, 1'b0);
    endtask

    task automatic outstanding_and_reset();
        int n = 0;
        send_cmd(32'h2000, 32'h100, 20'h0, 31, 31, 1'b0);
        dram_req_ready = 1'b1;
        wr_ready       = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            #1;
            if (dram_req_valid && dram_req_ready) n++;
        end
        chk("outs_limit_reqs", n, 8);
        chk("outs_limit_valid", dram_req_valid, 1'b0);
        @(negedge CLK);
        dram_resp_id    = {1'b0, 5'd3};
        dram_resp_data  = rand_data();
        dram_resp_valid = 1'b1;
        #1;
        chk("outs_resp_ready", dram_resp_ready, 1'b1);
        @(negedge CLK);
        dram_resp_valid = 1'b0;
        n = 0;
        repeat (10) begin
            #1;
            if (dram_req_valid && dram_req_ready) n++;
            @(negedge CLK);
        end
        chk("outs_one_more", n, 1);
        nRST = 1'b0;
        #1;
        chk("rst_mid_req", dram_req_valid, 1'b0);
        chk("rst_mid_wr", wr_valid, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        dram_resp_id    = {1'b0, 5'd4};
        dram_resp_valid = 1'b1;
        #1;
        chk("idle_resp_ready", dram_resp_ready, 1'b1);
        @(negedge CLK);
        dram_resp_valid = 1'b0;
        #1;
        chk("idle_drop_wr", wr_valid, 1'b0);
        chk("idle_drop_err", err, 1'b0);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST            = 1'b0;
        cmd_valid       = 1'b0;
        cmd_dram_addr   = '0;
        cmd_dram_stride = '0;
        cmd_spad_addr   = '0;
        cmd_rows_m1     = '0;
        cmd_cols_m1     = '0;
        cmd_scpad_id    = '0;
        dram_req_ready  = 1'b0;
        dram_resp_valid = 1'b0;
        dram_resp_id    = '0;
        dram_resp_data  = '0;
        wr_ready        = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_req_valid", dram_req_valid, 1'b0);
        chk("rst_resp_ready", dram_resp_ready, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req_addr", dram_req_addr, '0);
        chk("rst_wr_row", wr_row, '0);
        chk("rst_wr_data", wr_data, '0);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);

        run_tile(32'h1000, 32'h40, 20'h80, 3, 3, 1'b1, 0, 0, 0);
        run_tile(32'h8000, 32'h200, 20'h400, 31, 31, 1'b0, 1, 0, 0);
        outstanding_and_reset();
        run_tile(32'h3000, 32'h80, 20'h1000, 7, 9, 1'b1, 2, 0, 1);
        run_tile(32'h4000, 32'h40, 20'h2000, 5, 4, 1'b0, 0, 1, 0);
        run_tile(32'hFFFF_FFC0, 32'h40, 20'hFFFC0, 2, 1, 1'b1, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            run_tile($urandom, $urandom, 20'($urandom),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     1'($urandom), 2, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
